// File: rtl/traffic_light_monitor.sv
// Passive monitor for the junction light buses: decodes the 6-phase sequence and checks order and dwell.
// Optional dwell checking is enabled by defining TLM_DWELL_CHECK_EN; otherwise err_dwell is tied 0.
module traffic_light_monitor #(
  parameter int unsigned DWELL_P0 = 8,
  parameter int unsigned DWELL_P1 = 3,
  parameter int unsigned DWELL_P2 = 6,
  parameter int unsigned DWELL_P3 = 3,
  parameter int unsigned DWELL_P4 = 4,
  parameter int unsigned DWELL_P5 = 3,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_err,
  input  logic [2:0]       light_m1,
  input  logic [2:0]       light_m2,
  input  logic [2:0]       light_mt,
  input  logic [2:0]       light_s,
  output logic [2:0]       phase,
  output logic             phase_chg,
  output logic             locked,
  output logic             err_pattern,
  output logic             err_seq,
  output logic             err_dwell,
  output logic             err_any,
  output logic [CNT_W-1:0] round_cnt
);

  localparam logic [2:0] LG       = 3'b001;
  localparam logic [2:0] LY       = 3'b010;
  localparam logic [2:0] LR       = 3'b100;
  localparam logic [2:0] PH_NONE  = 3'd7;
  localparam logic [2:0] PH_LAST  = 3'd5;

  typedef enum logic {SYNC, LOCKED} state_t;

  state_t     state;
  logic [2:0] dec_ph;
  logic       dec_valid;
  logic [2:0] succ_ph;
  logic       is_succ;

  // Exact-match decode of the four lamp buses into a phase number
  always_comb begin
    dec_ph = PH_NONE;
    case ({light_m1, light_m2, light_mt, light_s})
      {LG, LG, LR, LR}: dec_ph = 3'd0;
      {LG, LY, LR, LR}: dec_ph = 3'd1;
      {LG, LR, LG, LR}: dec_ph = 3'd2;
      {LY, LR, LY, LR}: dec_ph = 3'd3;
      {LR, LR, LR, LG}: dec_ph = 3'd4;
      {LR, LR, LR, LY}: dec_ph = 3'd5;
      default:          dec_ph = PH_NONE;
    endcase
  end

  assign dec_valid = (dec_ph != PH_NONE);
  assign succ_ph   = (phase == PH_LAST) ? 3'd0 : phase + 3'd1;
  // A phase of 7 has no successor; the first valid sample after it is only a load
  assign is_succ   = (phase != PH_NONE) && (dec_ph == succ_ph);

`ifdef TLM_DWELL_CHECK_EN
  localparam int unsigned DW_W = 4;
  localparam logic [DW_W-1:0] DW_SAT = '1;

  logic [DW_W-1:0] dwell_cnt;

  function automatic logic [DW_W-1:0] dwell_of(input logic [2:0] p);
    case (p)
      3'd0:    dwell_of = DW_W'(DWELL_P0);
      3'd1:    dwell_of = DW_W'(DWELL_P1);
      3'd2:    dwell_of = DW_W'(DWELL_P2);
      3'd3:    dwell_of = DW_W'(DWELL_P3);
      3'd4:    dwell_of = DW_W'(DWELL_P4);
      3'd5:    dwell_of = DW_W'(DWELL_P5);
      default: dwell_of = '0;
    endcase
  endfunction
`else
  logic unused_dwell_params;
  assign unused_dwell_params = ^{DWELL_P0, DWELL_P1, DWELL_P2, DWELL_P3, DWELL_P4, DWELL_P5};
  assign err_dwell = 1'b0;
`endif

  assign err_any = err_pattern | err_seq | err_dwell;

  // Sync/lock tracker; error sets are written after the clear so a same-edge set wins
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= SYNC;
      phase       <= PH_NONE;
      phase_chg   <= 1'b0;
      locked      <= 1'b0;
      err_pattern <= 1'b0;
      err_seq     <= 1'b0;
      round_cnt   <= '0;
`ifdef TLM_DWELL_CHECK_EN
      err_dwell   <= 1'b0;
      dwell_cnt   <= '0;
`endif
    end else begin
      phase_chg <= 1'b0;
      if (clr_err) begin
        err_pattern <= 1'b0;
        err_seq     <= 1'b0;
`ifdef TLM_DWELL_CHECK_EN
        err_dwell   <= 1'b0;
`endif
      end

      if (!dec_valid) begin
        err_pattern <= 1'b1;
        phase       <= PH_NONE;
        state       <= SYNC;
        locked      <= 1'b0;
`ifdef TLM_DWELL_CHECK_EN
        dwell_cnt   <= '0;
`endif
      end else if (dec_ph != phase) begin
        phase     <= dec_ph;
        phase_chg <= 1'b1;
`ifdef TLM_DWELL_CHECK_EN
        dwell_cnt <= DW_W'(1);
`endif
        if (is_succ) begin
          state  <= LOCKED;
          locked <= 1'b1;
          if (state == LOCKED) begin
`ifdef TLM_DWELL_CHECK_EN
            if (dwell_cnt != dwell_of(phase)) err_dwell <= 1'b1;
`endif
            if (phase == PH_LAST) round_cnt <= round_cnt + CNT_W'(1);
          end
        end else if (phase != PH_NONE) begin
          err_seq <= 1'b1;
          state   <= SYNC;
          locked  <= 1'b0;
        end
      end else begin
`ifdef TLM_DWELL_CHECK_EN
        if (dwell_cnt != DW_SAT) dwell_cnt <= dwell_cnt + DW_W'(1);
        // Overrun flagged on the first sample past the required dwell
        if ((state == LOCKED) && (dwell_cnt == dwell_of(phase))) err_dwell <= 1'b1;
`endif
      end
    end
  end

endmodule

// File: doc/traffic_light_monitor.md
Name: traffic_light_monitor

Overview:
Passive checker on the four light buses of the junction controller (M1, M2, MT, S). It decodes the light patterns back into the 6-phase sequence, checks the phase order and per-phase dwell times, and counts completed rounds. It is used in simulation benches and as an on-chip safety watchdog next to the controller. It has no outputs that drive the lights.

Parameters:
DWELL_P0, 8, required samples in phase 0 (M1 G, M2 G, MT R, S R)
DWELL_P1, 3, phase 1 (M1 G, M2 Y, MT R, S R)
DWELL_P2, 6, phase 2 (M1 G, M2 R, MT G, S R)
DWELL_P3, 3, phase 3 (M1 Y, M2 R, MT Y, S R)
DWELL_P4, 4, phase 4 (M1 R, M2 R, MT R, S G)
DWELL_P5, 3, phase 5 (M1 R, M2 R, MT R, S Y)
CNT_W, 16, round counter width

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
clr_err  in  1  synchronous clear of sticky error flags
light_m1  in  3  main road 1 lamps; 001=G, 010=Y, 100=R
light_m2  in  3  main road 2 lamps; same encoding
light_mt  in  3  main turn lamps; same encoding
light_s  in  3  side road lamps; same encoding
phase  out  3  decoded phase 0..5; 7 = unknown
phase_chg  out  1  one-cycle pulse when phase changes to a valid value
locked  out  1  1 while in LOCKED state
err_pattern  out  1  sticky: undecodable light combination seen
err_seq  out  1  sticky: illegal phase successor
err_dwell  out  1  sticky: dwell-time violation
err_any  out  1  OR of the three error flags (combinational from the registered flags)
round_cnt  out  CNT_W  count of completed rounds (phase 5 to phase 0 while LOCKED)

Behaviour:
- Reset values: phase=7, phase_chg=0, locked=0, all err_*=0, round_cnt=0, dwell_cnt=0, state=SYNC.
- Lights are sampled on every posedge. All outputs are registered from that sample, giving 1-cycle latency.
- Decode: an exact match against the six patterns listed under Parameters gives phase 0..5. Any other combination is an invalid pattern.
- Legal successor is (p+1) mod 6.
- dwell_cnt: count of consecutive samples with the same phase.
  - Reload to 1 on a phase change.
  - Otherwise increment, saturating at 15.
- Invalid pattern (any state):
  - err_pattern<=1, phase<=7, dwell_cnt<=0, state<=SYNC, phase_chg=0.
- SYNC state:
  - First valid pattern loads phase and pulses phase_chg. No checks.
  - Change to a legal successor: pulse phase_chg, state<=LOCKED. No dwell check, because the first phase was only partly observed.
  - Change to a non-successor: err_seq<=1, phase updates, stay SYNC.
- LOCKED state, change to a legal successor:
  - If dwell_cnt != DWELL of the old phase, set err_dwell.
  - Pulse phase_chg.
  - If the change is 5 to 0, round_cnt+=1, wrapping at 2^CNT_W.
- LOCKED state, change to a non-successor:
  - err_seq<=1, phase updates, state<=SYNC, round_cnt unchanged.
- LOCKED state, same phase held:
  - On the sample where dwell_cnt already equals DWELL of the current phase (the overrun sample), set err_dwell immediately.
  - A later mismatch on the eventual change re-asserts it, which has no further effect because the flag is sticky.
- clr_err: clears the three flags on the next edge. If a new error is detected on the same edge, that flag is set (set wins). clr_err does not affect phase, state, or round_cnt.
- rst mid-operation: immediate return to reset values. The monitor resyncs from the next sample.
- Nominal round is 27 cycles. On a correct stream, every phase_chg after the first lock arrives with no error flag set.

Optional Feature:
TLM_DWELL_CHECK_EN:
- Defined: dwell checking as above.
- Undefined: the dwell_cnt logic and all dwell comparisons are removed, and err_dwell is tied 0. Decode, sequence checking, locked, and round_cnt are unchanged.

Test Plan:
1. Release rst, drive a correct stream starting at phase 0 for 3 rounds plus 1 phase-0 sample.
   - phase steps 0..5 with phase_chg on each change.
   - locked=1 from the first 0 to 1 change.
   - round_cnt=3, all err_*=0.
2. Mid-phase-2, drive light_m1=011 for one cycle.
   - Next edge: err_pattern=1, phase=7, locked=0, err_any=1.
   - Resume a correct stream from phase 3: relock after the 3 to 4 change, no further flags.
3. In LOCKED, go from phase 0 directly to phase 2.
   - err_seq=1, phase=2, locked=0, round_cnt unchanged.
4. Hold phase 0 for 9 samples in LOCKED.
   - err_dwell=1 on the edge of the 9th sample.
   - With TLM_DWELL_CHECK_EN undefined: err_dwell=0 and phase_chg timing is identical.
5. Hold phase 2 for 5 samples, then phase 3.
   - err_dwell=1 on the phase-3 edge, locked stays 1.
6. Assert clr_err on the same cycle an illegal successor is detected: err_seq stays 1.
   - Assert clr_err alone: all flags 0 next edge.
   - Assert rst during phase 2: outputs return to reset values. After the next 2 to 3 change, locked=1 and err_dwell=0.
